// File: rtl/oam_dma.sv
// oam_dma: sprite-DMA controller and CPU/system-bus arbiter.
//
// A CPU write to DMA_REG latches a source page, stalls the CPU through
// cpu_ready, then copies 256 bytes from {page,00..FF} to OAM_DATA as
// alternating read/write bus cycles. When no transfer is running, the
// block passes the CPU bus straight through.
//
// Ports
//   clk, reset       system clock; asynchronous active-high reset
//   cpu_addr/write/d_out   CPU bus outputs
//   d_in             system-bus read data (shared with the CPU)
//   cpu_ready        CPU ready input; low for the whole transfer
//   bus_addr/write/d_out   arbitrated bus towards the address decoder
//   dma_active       high in any state other than IDLE
//   dma_done         one-cycle pulse after the final OAM write
module oam_dma (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_d_out,
  input  logic [7:0]  d_in,
  output logic        cpu_ready,
  output logic [15:0] bus_addr,
  output logic        bus_write,
  output logic [7:0]  bus_d_out,
  output logic        dma_active,
  output logic        dma_done
);
  localparam logic [15:0] DMA_REG  = 16'h4014;
  localparam logic [15:0] OAM_DATA = 16'h2004;

  typedef enum logic [2:0] {S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE} state_t;

  state_t     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       odd_q, odd_d;
  logic       done_q, done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
      odd_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      odd_q   <= odd_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    idx_d     = idx_q;
    data_d    = data_q;
    odd_d     = ~odd_q;
    done_d    = 1'b0;
    bus_addr  = cpu_addr;
    bus_write = cpu_write;
    bus_d_out = cpu_d_out;
    case (state_q)
      S_IDLE: begin
        // The trigger write itself still reaches the bus.
        if (cpu_write && cpu_addr == DMA_REG) begin
          page_d  = cpu_d_out;
          idx_d   = 8'h00;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        // The CPU ignores ready on write cycles, so wait for a read.
        // Leaving from an odd cycle lands READ on an even one;
        // otherwise ALIGN burns one cycle to get there.
        if (!cpu_write) state_d = odd_q ? S_READ : S_ALIGN;
      end
      S_ALIGN: begin
        bus_write = 1'b0;
        state_d   = S_READ;
      end
      S_READ: begin
        bus_addr  = {page_q, idx_q};
        bus_write = 1'b0;
        data_d    = d_in;
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        bus_addr  = OAM_DATA;
        bus_write = 1'b1;
        bus_d_out = data_q;
        idx_d     = idx_q + 8'h01;
        if (idx_q == 8'hFF) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cpu_ready  = (state_q == S_IDLE);
  assign dma_active = (state_q != S_IDLE);
  assign dma_done   = done_q;
endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma. The stimulus process plans each transfer
// as a list of bus cycles (pass-through, HALT, optional ALIGN, 256
// read/write pairs, done pulse). It pushes one expected bus tuple per
// cycle. A monitor pops one tuple per cycle and compares it on the
// falling edge. The memory returns a fixed function of the address.
module tb_oam_dma;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = 16'h0;
  logic        cpu_write = 1'b0;
  logic [7:0]  cpu_d_out = 8'h0;
  logic [7:0]  d_in;
  logic        cpu_ready;
  logic [15:0] bus_addr;
  logic        bus_write;
  logic [7:0]  bus_d_out;
  logic        dma_active;
  logic        dma_done;

  oam_dma dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_write(cpu_write),
    .cpu_d_out(cpu_d_out), .d_in(d_in), .cpu_ready(cpu_ready),
    .bus_addr(bus_addr), .bus_write(bus_write), .bus_d_out(bus_d_out),
    .dma_active(dma_active), .dma_done(dma_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] memf(input logic [15:0] a);
    logic [7:0] hi;
    hi = a[15:8] * 8'd37;
    return a[7:0] ^ hi;
  endfunction

  assign d_in = memf(bus_addr);

  typedef struct packed {
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  dout;
    logic        rdy;
    logic        act;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total    = 0;
  bit   par      = 1'b0;  // parity of the next cycle to be driven
  bit   done_next = 1'b0;

  // Monitor: one expected tuple per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = '{bus_addr, bus_write, bus_d_out, cpu_ready, dma_active, dma_done};
      total++;
      if (g === e) pass_cnt++;
      else $display("FAIL cycle t=%0t got addr=%h wr=%b d=%h rdy=%b act=%b done=%b, required addr=%h wr=%b d=%h rdy=%b act=%b done=%b",
                    $time, g.addr, g.wr, g.dout, g.rdy, g.act, g.done,
                    e.addr, e.wr, e.dout, e.rdy, e.act, e.done);
    end
  end

  task automatic drive(input logic [15:0] a, input logic w, input logic [7:0] d,
                       input logic r, input exp_t e);
    @(posedge clk); #1;
    cpu_addr = a; cpu_write = w; cpu_d_out = d; reset = r;
    exp_q.push_back(e);
    par = r ? 1'b0 : ~par;
  endtask

  task automatic idle(input logic [15:0] a, input logic w, input logic [7:0] d);
    exp_t e;
    e = '{a, w, d, 1'b1, 1'b0, done_next};
    done_next = 1'b0;
    drive(a, w, d, 1'b0, e);
  endtask

  task automatic idle_rand(input int n);
    logic [15:0] a; logic w; logic [7:0] d;
    for (int k = 0; k < n; k++) begin
      a = 16'($urandom); w = 1'($urandom); d = 8'($urandom);
      if (w && a == 16'h4014) a = 16'h4015;
      idle(a, w, d);
    end
  endtask

  // Pad with an idle cycle so the HALT cycle lands on the wanted parity.
  task automatic set_halt_par(input bit want);
    if (par == want) idle(16'h8000, 1'b0, 8'h00);
  endtask

  task automatic run_dma(input logic [7:0] page, input int nhw,
                         input int retrig_i, input int rst_i);
    logic [15:0] a; logic w; logic [7:0] d; bit hp;
    idle(16'h4014, 1'b1, page);
    for (int k = 0; k < nhw; k++) begin
      a = (k == 0) ? 16'h4014 : 16'($urandom); d = 8'($urandom);
      drive(a, 1'b1, d, 1'b0, '{a, 1'b1, d, 1'b0, 1'b1, 1'b0});
    end
    a = 16'($urandom); d = 8'($urandom); hp = par;
    drive(a, 1'b0, d, 1'b0, '{a, 1'b0, d, 1'b0, 1'b1, 1'b0});
    if (!hp) begin
      a = 16'($urandom); w = 1'($urandom); d = 8'($urandom);
      drive(a, w, d, 1'b0, '{a, 1'b0, d, 1'b0, 1'b1, 1'b0});
    end
    for (int i = 0; i < 256; i++) begin
      a = 16'($urandom); w = 1'($urandom); d = 8'($urandom);
      if (i == retrig_i) begin a = 16'h4014; w = 1'b1; d = 8'h07; end
      if (i == rst_i) begin
        drive(a, w, d, 1'b1, '{a, w, d, 1'b1, 1'b0, 1'b0});
        done_next = 1'b0;
        return;
      end
      drive(a, w, d, 1'b0, '{{page, 8'(i)}, 1'b0, d, 1'b0, 1'b1, 1'b0});
      a = 16'($urandom); w = 1'($urandom); d = 8'($urandom);
      drive(a, w, d, 1'b0, '{16'h2004, 1'b1, memf({page, 8'(i)}), 1'b0, 1'b1, 1'b0});
    end
    done_next = 1'b1;
  endtask

  initial begin
    // Reset state: two cycles held in reset, bus follows CPU.
    drive(16'h1234, 1'b1, 8'hA5, 1'b1, '{16'h1234, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0});
    drive(16'h4014, 1'b1, 8'h09, 1'b1, '{16'h4014, 1'b1, 8'h09, 1'b1, 1'b0, 1'b0});
    // Pass-through.
    idle(16'h8000, 1'b0, 8'h00);
    idle(16'h0300, 1'b1, 8'h55);
    idle_rand(8);
    // Even-parity HALT (with ALIGN), then odd-parity HALT.
    set_halt_par(1'b0); run_dma(8'h02, 0, -1, -1); idle_rand(3);
    set_halt_par(1'b1); run_dma(8'h02, 0, -1, -1); idle_rand(3);
    // CPU writes during HALT (first one hits DMA_REG and is ignored).
    run_dma(8'h20, 2, -1, -1); idle_rand(2);
    // Retrigger mid-transfer.
    run_dma(8'h02, 0, 8'h40, -1); idle_rand(2);
    // Reset mid-transfer, then a fresh transfer from idx 0.
    run_dma(8'h02, 0, -1, 8'h80); idle_rand(3);
    run_dma(8'hFF, 0, -1, -1); idle_rand(2);
    // A few random transfers with random HALT write counts.
    for (int t = 0; t < 3; t++) begin
      run_dma(8'($urandom), int'($urandom_range(0, 3)), -1, -1);
      idle_rand(int'($urandom_range(1, 4)));
    end
    @(posedge clk); @(negedge clk); #1;
    total++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL drain got %0d pending, required 0", exp_q.size());
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
